// File: rtl/graph_mem_responder.sv
// graph_mem_responder: word-read responder for the Dijkstra engine.
// Holds a host-loadable graph array and answers in-order read requests
// a fixed LATENCY cycles after acceptance, with wait_request backpressure.

module graph_mem_responder #(
    parameter int DATA_WIDTH      = 32,
    parameter int DEPTH           = 256,
    parameter int LATENCY         = 3,
    parameter int MAX_OUTSTANDING = 2,
    localparam int ADDR_WIDTH     = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int COUNT_WIDTH    = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                  algorithm_clock,
    input  logic                  algorithm_reset_n,
    input  logic                  mem_read_enable,
    input  logic [31:0]           mem_addr,
    output logic                  wait_request,
    output logic                  mem_read_ready,
    output logic [DATA_WIDTH-1:0] mem_read_data,
    output logic                  addr_error,
    input  logic                  stall,
    input  logic                  load_enable,
    input  logic [ADDR_WIDTH-1:0] load_addr,
    input  logic [DATA_WIDTH-1:0] load_data
);

    logic [DATA_WIDTH-1:0]  mem [DEPTH];

    logic [30:0]            word_index;
    logic                   read_error;
    logic [DATA_WIDTH-1:0]  read_word;
    logic                   accept;
    logic                   retire;
    logic                   load_in_range;
    logic                   addr_lsb_unused;

    logic [COUNT_WIDTH-1:0] outstanding;
    logic [LATENCY-1:0]     stage_valid;
    logic [DATA_WIDTH-1:0]  stage_data [LATENCY];
    logic [LATENCY-1:0]     stage_err;

    // Bit 0 of the byte-style address carries no word information.
    assign addr_lsb_unused = mem_addr[0];
    assign word_index      = mem_addr[31:1];

    // Backpressure is purely the current count; a same-cycle retirement is not anticipated.
    assign wait_request = stall || (outstanding == COUNT_WIDTH'(MAX_OUTSTANDING));
    assign accept       = mem_read_enable && !wait_request;
    assign retire       = stage_valid[LATENCY-1];

    // Out-of-range indices read as zero and are flagged through the pipeline.
    always_comb begin
        read_error = ({1'b0, word_index} >= 32'(DEPTH));
        read_word  = '0;
        if (!read_error) begin
            read_word = mem[word_index[ADDR_WIDTH-1:0]];
        end
    end

    // Host writes beyond the array are dropped; a power-of-two depth cannot overflow.
    generate
        if ((1 << ADDR_WIDTH) > DEPTH) begin : g_load_check
            assign load_in_range = (32'(load_addr) < 32'(DEPTH));
        end else begin : g_load_nocheck
            assign load_in_range = 1'b1;
        end
    endgenerate

    // Array write port; contents survive reset, and a same-edge read still sees the old word.
    always_ff @(posedge algorithm_clock) begin
        if (load_enable && load_in_range) begin
            mem[load_addr] <= load_data;
        end
    end

    // Latency pipeline: valid always shifts, payload only moves with a valid so the last stage holds.
    always_ff @(posedge algorithm_clock or negedge algorithm_reset_n) begin
        if (!algorithm_reset_n) begin
            for (int i = 0; i < LATENCY; i++) begin
                stage_valid[i] <= 1'b0;
                stage_data[i]  <= '0;
                stage_err[i]   <= 1'b0;
            end
        end else begin
            stage_valid[0] <= accept;
            if (accept) begin
                stage_data[0] <= read_word;
                stage_err[0]  <= read_error;
            end
            for (int i = 1; i < LATENCY; i++) begin
                stage_valid[i] <= stage_valid[i-1];
                if (stage_valid[i-1]) begin
                    stage_data[i] <= stage_data[i-1];
                    stage_err[i]  <= stage_err[i-1];
                end
            end
        end
    end

    // Outstanding count: accepts add, the end of a ready cycle removes.
    always_ff @(posedge algorithm_clock or negedge algorithm_reset_n) begin
        if (!algorithm_reset_n) begin
            outstanding <= '0;
        end else if (accept && !retire) begin
            outstanding <= outstanding + COUNT_WIDTH'(1);
        end else if (retire && !accept) begin
            outstanding <= outstanding - COUNT_WIDTH'(1);
        end
    end

    assign mem_read_ready = stage_valid[LATENCY-1];
    assign mem_read_data  = stage_data[LATENCY-1];
    assign addr_error     = stage_valid[LATENCY-1] && stage_err[LATENCY-1];

endmodule

// File: tb/tb_graph_mem_responder.sv
// tb_graph_mem_responder: directed vector table, hand-written corner sequences
// and randomized traffic, all checked against a timestamped response-queue model.

module tb_graph_mem_responder;

    localparam int DW    = 32;
    localparam int DEPTH = 256;
    localparam int LAT   = 3;
    localparam int MAXO  = 2;
    localparam int AW    = 8;

    logic          algorithm_clock = 1'b0;
    logic          algorithm_reset_n;
    logic          mem_read_enable;
    logic [31:0]   mem_addr;
    logic          wait_request;
    logic          mem_read_ready;
    logic [DW-1:0] mem_read_data;
    logic          addr_error;
    logic          stall;
    logic          load_enable;
    logic [AW-1:0] load_addr;
    logic [DW-1:0] load_data;

    graph_mem_responder #(
        .DATA_WIDTH(DW), .DEPTH(DEPTH), .LATENCY(LAT), .MAX_OUTSTANDING(MAXO)
    ) dut (
        .algorithm_clock  (algorithm_clock),
        .algorithm_reset_n(algorithm_reset_n),
        .mem_read_enable  (mem_read_enable),
        .mem_addr         (mem_addr),
        .wait_request     (wait_request),
        .mem_read_ready   (mem_read_ready),
        .mem_read_data    (mem_read_data),
        .addr_error       (addr_error),
        .stall            (stall),
        .load_enable      (load_enable),
        .load_addr        (load_addr),
        .load_data        (load_data)
    );

    always #5 algorithm_clock = ~algorithm_clock;

    // Reference model: expected responses tagged with the edge they were accepted on
    typedef struct {
        logic [DW-1:0] data;
        logic          err;
        int            acc_edge;
    } resp_t;

    resp_t         pend_q[$];
    logic [DW-1:0] model_mem [DEPTH];
    logic [DW-1:0] model_last;
    int            edge_cnt;
    int            n_cmp;
    int            n_fail;

    typedef struct {
        logic          en;
        logic [31:0]   addr;
        logic          ld;
        logic [AW-1:0] ld_addr;
        logic [DW-1:0] ld_data;
        logic          exp_wait;
        logic          exp_ready;
        logic [DW-1:0] exp_data;
        logic          exp_err;
    } vec_t;

    vec_t vecs[22];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h, expected %h (edge %0d)", name, act, exp, edge_cnt);
        end
    endtask

    // One clock: check wait_request before the edge, update the model, check outputs after it
    task automatic applyStimulus(output logic wait_seen);
        logic  acc;
        resp_t r;
        logic [31:0] idx;
        logic  exp_wait, exp_ready, exp_err;
        @(negedge algorithm_clock);
        exp_wait = stall || (pend_q.size() == MAXO);
        wait_seen = wait_request;
        checkOutput("wait_request", {31'b0, wait_request}, {31'b0, exp_wait});
        acc = mem_read_enable && !exp_wait;
        idx = mem_addr >> 1;
        r.err = (idx >= DEPTH);
        r.data = r.err ? '0 : model_mem[idx[AW-1:0]];
        r.acc_edge = edge_cnt + 1;
        @(posedge algorithm_clock);
        edge_cnt++;
        if (acc) pend_q.push_back(r);
        if (load_enable) model_mem[load_addr] = load_data;
        while (pend_q.size() > 0 && pend_q[0].acc_edge + LAT == edge_cnt) void'(pend_q.pop_front());
        #1;
        exp_ready = (pend_q.size() > 0) && (pend_q[0].acc_edge + LAT - 1 == edge_cnt);
        exp_err = 1'b0;
        if (exp_ready) begin
            model_last = pend_q[0].data;
            exp_err = pend_q[0].err;
        end
        checkOutput("mem_read_ready", {31'b0, mem_read_ready}, {31'b0, exp_ready});
        checkOutput("mem_read_data", mem_read_data, model_last);
        checkOutput("addr_error", {31'b0, addr_error}, {31'b0, exp_err});
    endtask

    task automatic idleInputs();
        mem_read_enable = 1'b0;
        mem_addr = '0;
        stall = 1'b0;
        load_enable = 1'b0;
        load_addr = '0;
        load_data = '0;
    endtask

    function automatic vec_t mkVec(input logic en, input logic [31:0] addr, input logic ld,
                                   input logic [AW-1:0] la, input logic [DW-1:0] ldat,
                                   input logic w, input logic rdy, input logic [DW-1:0] d, input logic e);
        vec_t v;
        v.en = en; v.addr = addr; v.ld = ld; v.ld_addr = la; v.ld_data = ldat;
        v.exp_wait = w; v.exp_ready = rdy; v.exp_data = d; v.exp_err = e;
        return v;
    endfunction

    initial begin
        logic w;
        n_cmp = 0;
        n_fail = 0;
        edge_cnt = 0;
        model_last = '0;
        for (int i = 0; i < DEPTH; i++) model_mem[i] = 'x;

        // Directed table: single read, backpressure, odd/out-of-range address, load collision
        vecs[0]  = mkVec(1, 32'h0A, 0, 0, 0,        0, 0, 0, 0);
        vecs[1]  = mkVec(0, 32'h00, 0, 0, 0,        0, 0, 0, 0);
        vecs[2]  = mkVec(0, 32'h00, 0, 0, 0,        0, 1, 5, 0);
        vecs[3]  = mkVec(0, 32'h00, 0, 0, 0,        0, 0, 5, 0);
        vecs[4]  = mkVec(1, 32'h10, 0, 0, 0,        0, 0, 5, 0);
        vecs[5]  = mkVec(1, 32'h12, 0, 0, 0,        0, 0, 5, 0);
        vecs[6]  = mkVec(1, 32'h14, 0, 0, 0,        1, 1, 8, 0);
        vecs[7]  = mkVec(1, 32'h14, 0, 0, 0,        1, 1, 9, 0);
        vecs[8]  = mkVec(1, 32'h14, 0, 0, 0,        0, 0, 9, 0);
        vecs[9]  = mkVec(0, 32'h00, 0, 0, 0,        0, 0, 9, 0);
        vecs[10] = mkVec(0, 32'h00, 0, 0, 0,        0, 1, 10, 0);
        vecs[11] = mkVec(0, 32'h00, 0, 0, 0,        0, 0, 10, 0);
        vecs[12] = mkVec(1, 32'h0B, 0, 0, 0,        0, 0, 10, 0);
        vecs[13] = mkVec(1, 32'h200, 0, 0, 0,       0, 0, 10, 0);
        vecs[14] = mkVec(0, 32'h00, 0, 0, 0,        1, 1, 5, 0);
        vecs[15] = mkVec(0, 32'h00, 0, 0, 0,        1, 1, 0, 1);
        vecs[16] = mkVec(0, 32'h00, 0, 0, 0,        0, 0, 0, 0);
        vecs[17] = mkVec(1, 32'h0E, 1, 7, 32'h1234, 0, 0, 0, 0);
        vecs[18] = mkVec(1, 32'h0E, 0, 0, 0,        0, 0, 0, 0);
        vecs[19] = mkVec(0, 32'h00, 0, 0, 0,        1, 1, 7, 0);
        vecs[20] = mkVec(0, 32'h00, 0, 0, 0,        1, 1, 32'h1234, 0);
        vecs[21] = mkVec(0, 32'h00, 0, 0, 0,        0, 0, 32'h1234, 0);

        // Reset state
        idleInputs();
        algorithm_reset_n = 1'b0;
        #12;
        checkOutput("reset_ready", {31'b0, mem_read_ready}, 32'd0);
        checkOutput("reset_data", mem_read_data, 32'd0);
        checkOutput("reset_err", {31'b0, addr_error}, 32'd0);
        checkOutput("reset_wait", {31'b0, wait_request}, 32'd0);
        @(negedge algorithm_clock);
        algorithm_reset_n = 1'b1;

        // Preload array[i] = i through the host port
        for (int i = 0; i < DEPTH; i++) begin
            load_enable = 1'b1;
            load_addr = AW'(i);
            load_data = DW'(i);
            applyStimulus(w);
        end
        idleInputs();

        $display("[TB] directed vector table");
        for (int i = 0; i < 22; i++) begin
            mem_read_enable = vecs[i].en;
            mem_addr = vecs[i].addr;
            load_enable = vecs[i].ld;
            load_addr = vecs[i].ld_addr;
            load_data = vecs[i].ld_data;
            applyStimulus(w);
            checkOutput($sformatf("vec%0d_wait", i), {31'b0, w}, {31'b0, vecs[i].exp_wait});
            checkOutput($sformatf("vec%0d_ready", i), {31'b0, mem_read_ready}, {31'b0, vecs[i].exp_ready});
            checkOutput($sformatf("vec%0d_data", i), mem_read_data, vecs[i].exp_data);
            checkOutput($sformatf("vec%0d_err", i), {31'b0, addr_error}, {31'b0, vecs[i].exp_err});
        end
        idleInputs();

        // Stall for 4 cycles while an earlier read is in flight
        $display("[TB] stall sequence");
        mem_read_enable = 1'b1;
        mem_addr = 32'h06;
        applyStimulus(w);
        mem_addr = 32'h08;
        stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(w);
            checkOutput("stall_wait", {31'b0, w}, 32'd1);
            if (i == 1) begin
                checkOutput("stall_inflight_ready", {31'b0, mem_read_ready}, 32'd1);
                checkOutput("stall_inflight_data", mem_read_data, 32'd3);
            end
        end
        stall = 1'b0;
        applyStimulus(w);
        mem_read_enable = 1'b0;
        for (int i = 0; i < 3; i++) applyStimulus(w);
        checkOutput("post_stall_data", mem_read_data, 32'd4);

        // Reset with two requests in flight
        $display("[TB] reset mid-flight");
        mem_read_enable = 1'b1;
        mem_addr = 32'h02;
        applyStimulus(w);
        mem_addr = 32'h04;
        applyStimulus(w);
        mem_read_enable = 1'b0;
        #2;
        algorithm_reset_n = 1'b0;
        #1;
        checkOutput("rst_ready", {31'b0, mem_read_ready}, 32'd0);
        checkOutput("rst_data", mem_read_data, 32'd0);
        checkOutput("rst_err", {31'b0, addr_error}, 32'd0);
        checkOutput("rst_wait", {31'b0, wait_request}, 32'd0);
        @(posedge algorithm_clock);
        @(posedge algorithm_clock);
        @(negedge algorithm_clock);
        algorithm_reset_n = 1'b1;
        pend_q.delete();
        model_last = '0;
        for (int i = 0; i < 5; i++) applyStimulus(w);
        mem_read_enable = 1'b1;
        mem_addr = 32'h04;
        applyStimulus(w);
        mem_read_enable = 1'b0;
        applyStimulus(w);
        applyStimulus(w);
        checkOutput("post_rst_ready", {31'b0, mem_read_ready}, 32'd1);
        checkOutput("post_rst_data", mem_read_data, 32'd2);

        // Randomized traffic against the model
        $display("[TB] random traffic");
        for (int i = 0; i < 600; i++) begin
            if (!(mem_read_enable && w)) begin
                mem_read_enable = ($urandom_range(0, 3) != 0);
                mem_addr = 32'($urandom_range(0, 32'h21F));
            end
            stall = ($urandom_range(0, 7) == 0);
            load_enable = ($urandom_range(0, 3) == 0);
            load_addr = AW'($urandom_range(0, DEPTH - 1));
            load_data = $urandom;
            applyStimulus(w);
        end
        idleInputs();
        for (int i = 0; i < LAT + 2; i++) applyStimulus(w);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
